// File: rtl/ca_digit_group_buffer_pkg.sv
// Shared definitions for the digit-to-group buffer: digit encodings and FSM states.
package ca_buf_pkg;

    // Signed-digit encoding {plus, minus}
    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ILL  = 2'b11;

    typedef enum logic {
        W_FILL,
        W_PAD
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_HOLD
    } rd_state_t;

    // Illegal digits are stored as zero so they cannot bias the product.
    function automatic logic [1:0] dig_clean(input logic [1:0] d);
        return (d == DIG_ILL) ? DIG_ZERO : d;
    endfunction

endpackage

// File: rtl/ca_digit_group_buffer_if.sv
// Digit input and group output handshakes of the digit-to-group buffer.
interface ca_digit_group_buffer_if #(
    parameter int NUM_BITS = 4
) ();
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          x_digit;
    logic [1:0]          y_digit;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_BITS-1:0] x_plus;
    logic [NUM_BITS-1:0] x_minus;
    logic [NUM_BITS-1:0] y_plus;
    logic [NUM_BITS-1:0] y_minus;
    logic                out_last;

    // Buffer side
    modport slave (
        input  in_valid, x_digit, y_digit, in_last, out_ready,
        output in_ready, out_valid, x_plus, x_minus, y_plus, y_minus, out_last
    );

    // Producer / consumer side
    modport master (
        output in_valid, x_digit, y_digit, in_last, out_ready,
        input  in_ready, out_valid, x_plus, x_minus, y_plus, y_minus, out_last
    );
endinterface

// File: rtl/ca_digit_group_buffer_bank_ram.sv
// One digit bank: simple dual-port RAM, 4-bit word {x+, x-, y+, y-}, synchronous read.
module ca_bank_ram #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [3:0]            wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [3:0]            rdata
);
    logic [3:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Write port and registered read port; no reset on storage
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ca_digit_group_buffer.sv
// Packs NUM_BITS signed-digit pairs into one group across NUM_BITS banks and
// presents complete groups as unrolled plus/minus vectors.
module ca_digit_group_buffer
    import ca_buf_pkg::*;
#(
    parameter int NUM_BITS   = 4,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    ca_digit_group_buffer_if.slave  bus,
    output logic [ADDR_WIDTH:0]     level,
    output logic                    err_illegal
);
    localparam int DIG_W = $clog2(NUM_BITS);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [DIG_W-1:0]    DIG_LAST = DIG_W'(NUM_BITS - 1);
    localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_ONE  = (ADDR_WIDTH+1)'(1);

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic [DIG_W-1:0]      wr_dig;
    logic [ADDR_WIDTH-1:0] wr_grp, rd_grp, rd_addr;
    logic [DEPTH-1:0]      last_q;

    logic       acc_rdy, wr_en, commit, commit_last, err_set;
    logic [3:0] wr_word;
    logic       rd_en, pop, cap;

    logic [NUM_BITS-1:0][3:0] rd_word;
    logic [NUM_BITS-1:0]      grp_xp, grp_xm, grp_yp, grp_ym;
    logic [NUM_BITS-1:0]      xp_q, xm_q, yp_q, ym_q;
    logic                     out_valid_q, out_last_q;

    // Banks: bank k holds the k-th digit of every group and drives output bit NUM_BITS-1-k
    for (genvar k = 0; k < NUM_BITS; k++) begin : g_bank
        ca_bank_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
            .clk   (clk),
            .we    (wr_en && (wr_dig == DIG_W'(k))),
            .waddr (wr_grp),
            .wdata (wr_word),
            .re    (rd_en),
            .raddr (rd_addr),
            .rdata (rd_word[k])
        );
        assign grp_xp[NUM_BITS-1-k] = rd_word[k][3];
        assign grp_xm[NUM_BITS-1-k] = rd_word[k][2];
        assign grp_yp[NUM_BITS-1-k] = rd_word[k][1];
        assign grp_ym[NUM_BITS-1-k] = rd_word[k][0];
    end

    // Write FSM: accept digits, zero-pad short operands, decide group commits
    always_comb begin
        w_next      = w_state;
        acc_rdy     = 1'b0;
        wr_en       = 1'b0;
        wr_word     = 4'b0000;
        commit      = 1'b0;
        commit_last = 1'b0;
        err_set     = 1'b0;
        case (w_state)
            W_FILL: begin
                acc_rdy = (level != LVL_FULL) && !flush;
                if (bus.in_valid && acc_rdy) begin
                    wr_en   = 1'b1;
                    wr_word = {dig_clean(bus.x_digit), dig_clean(bus.y_digit)};
                    err_set = (bus.x_digit == DIG_ILL) || (bus.y_digit == DIG_ILL);
                    if (wr_dig == DIG_LAST) begin
                        commit      = 1'b1;
                        commit_last = bus.in_last;
                    end else if (bus.in_last) begin
                        w_next = W_PAD;
                    end
                end
            end
            W_PAD: begin
                wr_en = 1'b1;
                if (wr_dig == DIG_LAST) begin
                    commit      = 1'b1;
                    commit_last = 1'b1;
                    w_next      = W_FILL;
                end
            end
            default: w_next = W_FILL;
        endcase
    end

    // Write-side state: digit index wraps to 0 on commit since NUM_BITS is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state     <= W_FILL;
            wr_dig      <= '0;
            wr_grp      <= '0;
            last_q      <= '0;
            err_illegal <= 1'b0;
        end else if (flush) begin
            w_state     <= W_FILL;
            wr_dig      <= '0;
            wr_grp      <= '0;
            err_illegal <= 1'b0;
        end else begin
            w_state <= w_next;
            if (wr_en) wr_dig <= wr_dig + 1'b1;
            if (commit) begin
                wr_grp         <= wr_grp + 1'b1;
                last_q[wr_grp] <= commit_last;
            end
            if (err_set) err_illegal <= 1'b1;
        end
    end

    // Read FSM: fetch from banks, hold group until consumer takes it
    always_comb begin
        r_next  = r_state;
        rd_en   = 1'b0;
        rd_addr = rd_grp;
        pop     = 1'b0;
        cap     = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (level != '0) begin
                    rd_en  = 1'b1;
                    r_next = R_FETCH;
                end
            end
            R_FETCH: begin
                cap    = 1'b1;
                r_next = R_HOLD;
            end
            R_HOLD: begin
                if (bus.out_ready) begin
                    pop = 1'b1;
                    if (level > LVL_ONE) begin
                        rd_en   = 1'b1;
                        rd_addr = rd_grp + 1'b1;
                        r_next  = R_FETCH;
                    end else begin
                        r_next = R_IDLE;
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read-side state and output register; data only changes on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= R_IDLE;
            rd_grp      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            xp_q <= '0; xm_q <= '0; yp_q <= '0; ym_q <= '0;
        end else if (flush) begin
            r_state     <= R_IDLE;
            rd_grp      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            xp_q <= '0; xm_q <= '0; yp_q <= '0; ym_q <= '0;
        end else begin
            r_state <= r_next;
            if (pop) rd_grp <= rd_grp + 1'b1;
            if (cap) begin
                xp_q <= grp_xp; xm_q <= grp_xm; yp_q <= grp_yp; ym_q <= grp_ym;
                out_last_q  <= last_q[rd_grp];
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Occupancy: a commit and a pop on the same edge cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               level <= '0;
        else if (flush)           level <= '0;
        else if (commit && !pop)  level <= level + 1'b1;
        else if (pop && !commit)  level <= level - 1'b1;
    end

    assign bus.in_ready  = acc_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.x_plus    = xp_q;
    assign bus.x_minus   = xm_q;
    assign bus.y_plus    = yp_q;
    assign bus.y_minus   = ym_q;

endmodule

// File: tb/tb_ca_digit_group_buffer.sv
// Directed bench for ca_digit_group_buffer with a group scoreboard.
module tb_ca_digit_group_buffer;
    localparam int NB = 4;
    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [AW:0] level;
    logic        err_illegal;

    ca_digit_group_buffer_if #(.NUM_BITS(NB)) bus ();

    ca_digit_group_buffer #(.NUM_BITS(NB), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .level       (level),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] xp, xm, yp, ym;
        logic          last;
    } grp_t;

    grp_t sb[$];
    grp_t cur = '0;
    int   cur_idx = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [1:0] dig_tab [3] = '{2'b00, 2'b10, 2'b01};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of group packing; illegal digits become zero
    task automatic model_accept(input logic [1:0] x, input logic [1:0] y, input logic last);
        logic [1:0] xc, yc;
        xc = (x == 2'b11) ? 2'b00 : x;
        yc = (y == 2'b11) ? 2'b00 : y;
        cur.xp[NB-1-cur_idx] = xc[1];
        cur.xm[NB-1-cur_idx] = xc[0];
        cur.yp[NB-1-cur_idx] = yc[1];
        cur.ym[NB-1-cur_idx] = yc[0];
        if (cur_idx == NB-1 || last) begin
            cur.last = last;
            sb.push_back(cur);
            cur = '0;
            cur_idx = 0;
        end else begin
            cur_idx++;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [1:0] x, input logic [1:0] y, input logic last);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.x_digit  = x;
        bus.y_digit  = y;
        bus.in_last  = last;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
        end
        if (ok) begin
            @(posedge clk); #1;
            model_accept(x, y, last);
        end else begin
            chk("in_ready_timeout", 32'(bus.in_ready), 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid && level == '0) break;
        end
        chk("drain_sb", 32'(sb.size()), 0);
        chk("drain_level", 32'(level), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_out_valid();
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        chk("out_valid_wait", 32'(bus.out_valid), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_out_last"},  32'(bus.out_last), 0);
        chk({tag, "_level"},     32'(level), 0);
        chk({tag, "_err"},       32'(err_illegal), 0);
        chk({tag, "_data"},      32'({bus.x_plus, bus.x_minus, bus.y_plus, bus.y_minus}), 0);
    endtask

    // Scoreboard: compare every group the consumer takes
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_underflow observed=unexpected_group expected=none");
            end
            if (sb.size() != 0) begin
                grp_t e;
                e = sb.pop_front();
                chk("grp_x_plus",  32'(bus.x_plus),  32'(e.xp));
                chk("grp_x_minus", 32'(bus.x_minus), 32'(e.xm));
                chk("grp_y_plus",  32'(bus.y_plus),  32'(e.yp));
                chk("grp_y_minus", 32'(bus.y_minus), 32'(e.ym));
                chk("grp_last",    32'(bus.out_last), 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.x_digit  = 2'b00;
        bus.y_digit  = 2'b00;
        bus.in_last  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;

        // Basic group and 2-cycle latency
        bus.out_ready = 1'b1;
        send(2'b10, 2'b00, 0);
        send(2'b01, 2'b10, 0);
        send(2'b00, 2'b10, 0);
        send(2'b10, 2'b01, 0);
        @(negedge clk); chk("lat_c1", 32'(bus.out_valid), 0);
        @(negedge clk); chk("lat_c2", 32'(bus.out_valid), 0);
        @(negedge clk); chk("lat_c3", 32'(bus.out_valid), 1);
        chk("t1_x_plus",  32'(bus.x_plus),  32'(4'b1001));
        chk("t1_x_minus", 32'(bus.x_minus), 32'(4'b0100));
        chk("t1_y_plus",  32'(bus.y_plus),  32'(4'b0110));
        chk("t1_y_minus", 32'(bus.y_minus), 32'(4'b0001));
        chk("t1_last",    32'(bus.out_last), 0);
        wait_drain();

        // Short operand: last on 2nd digit, two pad cycles
        send(2'b10, 2'b10, 0);
        send(2'b01, 2'b01, 1);
        @(negedge clk); chk("pad_c1", 32'(bus.in_ready), 0);
        @(negedge clk); chk("pad_c2", 32'(bus.in_ready), 0);
        @(negedge clk); chk("pad_c3", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        wait_drain();

        // Fill to DEPTH with consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4*NB; i++)
            send(dig_tab[$urandom_range(0, 2)], dig_tab[$urandom_range(0, 2)], 0);
        @(negedge clk);
        chk("full_level", 32'(level), 4);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        wait_out_valid();
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("pop_in_ready", 32'(bus.in_ready), 1);
        chk("pop_level", 32'(level), 3);
        @(posedge clk); #1;

        // Commit and pop on the same edge
        for (int i = 0; i < NB-1; i++)
            send(dig_tab[$urandom_range(0, 2)], dig_tab[$urandom_range(0, 2)], 0);
        bus.out_ready = 1'b1;
        send(2'b01, 2'b10, 0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("coinc_level", 32'(level), 3);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain();

        // Illegal digits: stored as zero, sticky error
        send(2'b11, 2'b10, 0);
        @(negedge clk);
        chk("ill_err", 32'(err_illegal), 1);
        @(posedge clk); #1;
        send(2'b10, 2'b11, 0);
        send(2'b01, 2'b01, 0);
        send(2'b10, 2'b00, 0);
        wait_drain();
        chk("ill_err_held", 32'(err_illegal), 1);

        // Flush with a group held and a partial group in progress
        bus.out_ready = 1'b0;
        send(2'b10, 2'b01, 0);
        send(2'b01, 2'b10, 0);
        send(2'b10, 2'b10, 0);
        send(2'b01, 2'b01, 0);
        send(2'b10, 2'b00, 0);
        send(2'b00, 2'b10, 0);
        wait_out_valid();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        sb.delete();
        cur = '0;
        cur_idx = 0;
        @(negedge clk);
        chk("flush_err", 32'(err_illegal), 0);
        chk("flush_level", 32'(level), 0);
        chk("flush_out_valid", 32'(bus.out_valid), 0);
        chk("flush_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(2'b01, 2'b00, 0);
        send(2'b10, 2'b10, 0);
        send(2'b00, 2'b01, 0);
        send(2'b01, 2'b10, 1);
        wait_drain();

        // Reset in the middle of a group
        send(2'b10, 2'b10, 0);
        send(2'b10, 2'b01, 0);
        rst_n = 1'b0;
        cur = '0;
        cur_idx = 0;
        @(negedge clk);
        chk_reset_vals("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(2'b00, 2'b10, 0);
        send(2'b01, 2'b00, 0);
        send(2'b10, 2'b01, 0);
        send(2'b01, 2'b10, 0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
